gpio_in_debounce: RTL and testbench



---
 rtl/gpio_in_pkg.sv | 24 ++
 rtl/gpio_in_debounce_bit.sv | 63 ++++++
 rtl/gpio_in_debounce.sv | 80 ++++++++
 tb/tb_gpio_in_debounce.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_in_pkg.sv
// gpio_in_pkg
// Shared constants and helpers for the GPIO input-conditioning block.
//   TICK_DIV_12MHZ_100US : prescaler divide for a 100 us tick at 12 MHz
//   STABLE_TICKS_5MS     : tick count giving a 5 ms accept window
//   clog2()              : ceiling log2, used to size counters
package gpio_in_pkg;

  localparam int TICK_DIV_12MHZ_100US = 1200;
  localparam int STABLE_TICKS_5MS     = 50;

  // Ceiling log2. Callers always pass values >= 2, so the result is never 0.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/gpio_in_debounce_bit.sv
// debounce_bit
// Single-bit synchroniser and debouncer driven by a shared tick.
//   clk, reset : system clock, synchronous active-high reset
//   pin        : raw asynchronous pin level
//   tick       : one-cycle timebase strobe from the shared prescaler
//   level      : debounced level
//   rise, fall : one-cycle strobes coincident with an accepted level change
module debounce_bit
  import gpio_in_pkg::*;
#(
  parameter int   STABLE_TICKS = STABLE_TICKS_5MS,
  parameter logic RESET_VAL    = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  input  logic tick,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int            CW   = clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

  logic          meta;
  logic          sync;
  logic [CW-1:0] count;

  // Two-flop synchroniser followed by the tick counter. Any cycle where the
  // synchronised level agrees with the debounced level wipes the count, so a
  // glitch shorter than the accept window leaves no trace. The count only
  // advances on ticks, and the level flips on the tick that completes the
  // window, with the matching strobe raised on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta  <= RESET_VAL;
      sync  <= RESET_VAL;
      level <= RESET_VAL;
      count <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      meta <= pin;
      sync <= meta;
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync == level) begin
        count <= '0;
      end else if (tick) begin
        if (count == LAST) begin
          level <= sync;
          count <= '0;
          rise  <= sync;
          fall  <= ~sync;
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/gpio_in_debounce.sv
// gpio_in_debounce
// Conditions raw board pins for the CPU gpio_i bus: synchronise, debounce
// with a shared prescaled timebase, and raise sticky edge flags plus a
// masked interrupt request.
//   clk, reset : system clock, synchronous active-high reset
//   pins_i     : raw asynchronous pin levels
//   gpio_i     : debounced levels
//   rise, fall : one-cycle strobes on accepted edges
//   irq_en     : per-bit interrupt mask
//   irq_clr    : write-1-to-clear for flags, sampled every cycle
//   flags      : sticky edge flags
//   irq        : registered OR of (flags & irq_en)
module gpio_in_debounce
  import gpio_in_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter int               TICK_DIV     = TICK_DIV_12MHZ_100US,
  parameter int               STABLE_TICKS = STABLE_TICKS_5MS,
  parameter logic [WIDTH-1:0] RESET_VAL    = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pins_i,
  output logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  input  logic [WIDTH-1:0] irq_en,
  input  logic [WIDTH-1:0] irq_clr,
  output logic [WIDTH-1:0] flags,
  output logic             irq
);

  localparam int            PW       = clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] prescale;
  logic          tick;

  // Free-running prescaler; pin activity never restarts it, so the accept
  // latency varies by up to one tick period with its phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescale <= '0;
    end else if (prescale == PRE_LAST) begin
      prescale <= '0;
    end else begin
      prescale <= prescale + 1'b1;
    end
  end

  assign tick = (prescale == PRE_LAST);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .STABLE_TICKS (STABLE_TICKS),
      .RESET_VAL    (RESET_VAL[i])
    ) u_bit (
      .clk   (clk),
      .reset (reset),
      .pin   (pins_i[i]),
      .tick  (tick),
      .level (gpio_i[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

  // Sticky flags: a new edge wins over a simultaneous clear so no event is
  // lost. irq is taken from the registered flags, trailing them by a cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags <= '0;
      irq   <= 1'b0;
    end else begin
      flags <= (flags & ~irq_clr) | rise | fall;
      irq   <= |(flags & irq_en);
    end
  end

endmodule

// File: tb/tb_gpio_in_debounce.sv
// tb_gpio_in_debounce
// Self-checking bench for gpio_in_debounce with a short timebase
// (TICK_DIV=4, STABLE_TICKS=3). A behavioural model predicts every output
// each cycle; directed phases exercise glitch, bounce, clear and reset cases.
module tb_gpio_in_debounce;

  localparam int         W  = 8;
  localparam int         TD = 4;
  localparam int         ST = 3;
  localparam logic [7:0] RV = 8'h00;

  logic         clk;
  logic         reset;
  logic [W-1:0] pins_i;
  logic [W-1:0] gpio_i;
  logic [W-1:0] rise;
  logic [W-1:0] fall;
  logic [W-1:0] irq_en;
  logic [W-1:0] irq_clr;
  logic [W-1:0] flags;
  logic         irq;

  gpio_in_debounce #(
    .WIDTH        (W),
    .TICK_DIV     (TD),
    .STABLE_TICKS (ST),
    .RESET_VAL    (RV)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .pins_i  (pins_i),
    .gpio_i  (gpio_i),
    .rise    (rise),
    .fall    (fall),
    .irq_en  (irq_en),
    .irq_clr (irq_clr),
    .flags   (flags),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state. Edges after reset are numbered from 0, which puts
  // a tick on every edge k with k % TD == TD-1. A bit accepts its new level
  // on the tick edge at which the current unbroken mismatch has seen ST ticks.
  logic [7:0] hist[$];
  logic [7:0] m_g, m_rise, m_fall, m_flags;
  logic       m_irq;
  int         mstart[W];
  int         kc;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic modelStep(input logic [7:0] p, input logic [7:0] en,
                           input logic [7:0] clr, input logic r);
    logic [7:0] s_old, ng, nr, nf;
    logic       tk;
    if (r) begin
      m_g = RV; m_rise = '0; m_fall = '0; m_flags = '0; m_irq = 1'b0;
      hist.delete(); hist.push_back(RV); hist.push_back(RV);
      for (int i = 0; i < W; i++) mstart[i] = -1;
      kc = 0;
    end else begin
      s_old = hist[0];
      tk    = (kc % TD) == TD - 1;
      for (int i = 0; i < W; i++) begin
        ng[i] = m_g[i]; nr[i] = 1'b0; nf[i] = 1'b0;
        if (s_old[i] == m_g[i]) begin
          mstart[i] = -1;
        end else begin
          if (mstart[i] < 0) mstart[i] = kc;
          if (tk && ((kc + 1) / TD - mstart[i] / TD) == ST) begin
            ng[i] = s_old[i]; nr[i] = s_old[i]; nf[i] = ~s_old[i];
            mstart[i] = -1;
          end
        end
      end
      m_irq   = |(m_flags & en);
      m_flags = (m_flags & ~clr) | m_rise | m_fall;
      m_g = ng; m_rise = nr; m_fall = nf;
      void'(hist.pop_front());
      hist.push_back(p);
      kc++;
    end
  endtask

  // One clock cycle: drive inputs, let the edge happen, advance the model,
  // then compare every output a little after the edge.
  task automatic applyStimulus(input logic [7:0] p, input logic [7:0] en,
                               input logic [7:0] clr, input logic r);
    pins_i = p; irq_en = en; irq_clr = clr; reset = r;
    @(posedge clk);
    modelStep(p, en, clr, r);
    #1;
    checkOutput("gpio_i", 32'(gpio_i), 32'(m_g));
    checkOutput("rise",   32'(rise),   32'(m_rise));
    checkOutput("fall",   32'(fall),   32'(m_fall));
    checkOutput("flags",  32'(flags),  32'(m_flags));
    checkOutput("irq",    32'(irq),    32'(m_irq));
  endtask

  logic [7:0] cur;
  logic [7:0] en;
  logic [7:0] clr;
  int         n;
  int         cnt;

  initial begin
    pins_i = '0; irq_en = '0; irq_clr = '0; reset = 1'b1;
    cur = 8'h00; en = 8'h01;

    // Reset, then 100 quiet cycles with pins low.
    applyStimulus(cur, en, 8'h00, 1'b1);
    applyStimulus(cur, en, 8'h00, 1'b1);
    checkOutput("reset_gpio", 32'(gpio_i), 32'(RV));
    checkOutput("reset_flags", 32'(flags), 0);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(cur, en, 8'h00, 1'b0);
      if ((rise | fall | flags) != 0 || irq) cnt++;
    end
    checkOutput("quiet_activity", cnt, 0);

    // Bit 0 rises and is held: latency window, flag, irq.
    cur[0] = 1'b1;
    n = 0;
    do begin
      applyStimulus(cur, en, 8'h00, 1'b0);
      n++;
    end while (!gpio_i[0] && n < 30);
    checkOutput("lat_rise0_ok", 32'(n >= 11 && n <= 14), 1);
    checkOutput("rise0_strobe", 32'(rise[0]), 1);
    applyStimulus(cur, en, 8'h00, 1'b0);
    checkOutput("rise0_width", 32'(rise[0]), 0);
    checkOutput("flag0_set", 32'(flags[0]), 1);
    applyStimulus(cur, en, 8'h00, 1'b0);
    checkOutput("irq_after_flag", 32'(irq), 1);

    // Glitch on bit 1 shorter than the accept window.
    cnt = 0;
    cur[1] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(cur, en, 8'h00, 1'b0);
      cnt += int'(rise[1]);
    end
    cur[1] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(cur, en, 8'h00, 1'b0);
      cnt += int'(rise[1]);
    end
    checkOutput("glitch_rise1", cnt, 0);
    checkOutput("glitch_gpio1", 32'(gpio_i[1]), 0);

    // Bounce on bit 2, then a steady high.
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) cur[2] = ~cur[2];
      applyStimulus(cur, en, 8'h00, 1'b0);
      cnt += int'(rise[2]);
    end
    checkOutput("bounce_early_rise2", cnt, 0);
    cur[2] = 1'b1;
    for (int i = 0; i < 25; i++) begin
      applyStimulus(cur, en, 8'h00, 1'b0);
      cnt += int'(rise[2]);
    end
    checkOutput("bounce_rise2_count", cnt, 1);

    // Clear flag 2 so only flag 0 is left, then clear coinciding with fall[0].
    applyStimulus(cur, en, 8'h04, 1'b0);
    applyStimulus(cur, en, 8'h00, 1'b0);
    checkOutput("flags_only0", 32'(flags), 32'h01);
    cur[0] = 1'b0;
    n = 0;
    do begin
      clr = m_fall[0] ? 8'h01 : 8'h00;
      applyStimulus(cur, en, clr, 1'b0);
      n++;
    end while (clr == 8'h00 && n < 30);
    checkOutput("clr_vs_fall_flag0", 32'(flags[0]), 1);
    applyStimulus(cur, en, 8'h00, 1'b0);
    applyStimulus(cur, en, 8'h01, 1'b0);
    checkOutput("clr_alone_flags", 32'(flags), 0);
    applyStimulus(cur, en, 8'h00, 1'b0);
    checkOutput("irq_after_clr", 32'(irq), 0);

    // Reset while bit 3 is two ticks into its window.
    cur[3] = 1'b1;
    n = 0;
    do begin
      applyStimulus(cur, en, 8'h00, 1'b0);
      n++;
    end while (!(mstart[3] >= 0 && (kc / TD - mstart[3] / TD) == 2) && n < 30);
    checkOutput("reach_count2", 32'(n < 30), 1);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(cur, en, 8'h00, 1'b1);
      cnt += int'((rise | fall) != 0);
    end
    checkOutput("no_strobe_in_reset", cnt, 0);
    n = 0;
    do begin
      applyStimulus(cur, en, 8'h00, 1'b0);
      n++;
    end while (!gpio_i[3] && n < 30);
    checkOutput("lat_after_reset_ok", 32'(n >= 11 && n <= 14), 1);

    // Random traffic with slowly changing pins, random masks, clears, resets.
    for (int i = 0; i < 900; i++) begin
      for (int b = 0; b < W; b++)
        if ($urandom_range(0, 11) == 0) cur[b] = ~cur[b];
      if (i % 50 == 0) en = 8'($urandom);
      clr = ($urandom_range(0, 6) == 0) ? 8'($urandom) : 8'h00;
      applyStimulus(cur, en, clr, $urandom_range(0, 399) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
